// File: rtl/fence_link_tx.sv
// Transmit side of the board-to-board fencing link: frames each player update as a
// 14-byte 8N1 UART packet. Define FENCE_LINK_TX_CRC8_EN to replace the XOR checksum with CRC-8 (0x07).
module fence_link_tx #(
  parameter int unsigned CLKS_PER_BIT = 644,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk_pixel_in,
  input  logic        rst_n_in,
  input  logic [88:0] data_in,
  input  logic        scored_in,
  input  logic        data_valid_in,
  output logic        tx_out,
  output logic        busy_out,
  output logic        packet_done_out,
  output logic [7:0]  overwrite_count_out
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_BYTE = 4'd13;
  localparam logic [3:0]  LAST_PAYLOAD_BYTE = 4'd12;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // One byte of checksum update; the CRC variant folds a whole byte per call.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
`ifdef FENCE_LINK_TX_CRC8_EN
    logic [7:0] c;
    c = acc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
`else
    return acc ^ b;
`endif
  endfunction

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [95:0] payload_q, payload_d;
  logic [7:0]  csum_q, csum_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_scored_q, pend_scored_d;
  logic [88:0] pend_data_q, pend_data_d;
  logic [7:0]  ovf_q, ovf_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        bit_end;
  logic        launch_window;
  logic        launch_cand;
  logic [88:0] launch_data;
  logic        launch_scored;

  always_comb begin
    state_d       = state_q;
    baud_d        = baud_q;
    bit_d         = bit_q;
    byte_idx_d    = byte_idx_q;
    shift_d       = shift_q;
    payload_d     = payload_q;
    csum_d        = csum_q;
    pend_valid_d  = pend_valid_q;
    pend_scored_d = pend_scored_q;
    pend_data_d   = pend_data_q;
    ovf_d         = ovf_q;
    done_d        = 1'b0;
    launch_window = 1'b0;
    bit_end       = (baud_q == BAUD_LAST);

    case (state_q)
      IDLE: begin
        launch_window = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          baud_d  = 16'd0;
          bit_d   = 3'd0;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = 16'd0;
          if (byte_idx_q == LAST_BYTE) begin
            done_d        = 1'b1;
            state_d       = IDLE;
            launch_window = 1'b1;
          end else begin
            state_d    = START;
            byte_idx_d = byte_idx_q + 4'd1;
            if (byte_idx_q == LAST_PAYLOAD_BYTE) begin
              shift_d = csum_q;
            end else begin
              // Payload is consumed LSB byte first; the checksum tracks each byte as it is loaded.
              shift_d   = payload_q[7:0];
              payload_d = {8'h00, payload_q[95:8]};
              csum_d    = csum_step(csum_q, payload_q[7:0]);
            end
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    launch_cand   = data_valid_in | pend_valid_q;
    launch_data   = data_valid_in ? data_in : pend_data_q;
    launch_scored = data_valid_in ? (scored_in | pend_scored_q) : pend_scored_q;

    if (launch_window && launch_cand) begin
      state_d       = START;
      baud_d        = 16'd0;
      bit_d         = 3'd0;
      byte_idx_d    = 4'd0;
      shift_d       = SYNC_BYTE;
      payload_d     = {6'b0, launch_scored, launch_data};
      csum_d        = 8'h00;
      pend_valid_d  = 1'b0;
      pend_scored_d = 1'b0;
    end else if (data_valid_in) begin
      // Only reachable while a packet is in flight: park the update, keep any score sticky.
      pend_data_d   = data_in;
      pend_scored_d = pend_scored_q | scored_in;
      pend_valid_d  = 1'b1;
      if (pend_valid_q && (ovf_q != 8'hFF)) begin
        ovf_d = ovf_q + 8'd1;
      end
    end

    tx_d   = (state_d == DATA) ? shift_d[0] : (state_d != START);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_pixel_in) begin
    if (!rst_n_in) begin
      state_q       <= IDLE;
      baud_q        <= 16'd0;
      bit_q         <= 3'd0;
      byte_idx_q    <= 4'd0;
      shift_q       <= 8'h00;
      payload_q     <= 96'd0;
      csum_q        <= 8'h00;
      pend_valid_q  <= 1'b0;
      pend_scored_q <= 1'b0;
      pend_data_q   <= 89'd0;
      ovf_q         <= 8'h00;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_q         <= bit_d;
      byte_idx_q    <= byte_idx_d;
      shift_q       <= shift_d;
      payload_q     <= payload_d;
      csum_q        <= csum_d;
      pend_valid_q  <= pend_valid_d;
      pend_scored_q <= pend_scored_d;
      pend_data_q   <= pend_data_d;
      ovf_q         <= ovf_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign tx_out              = tx_q;
  assign busy_out            = busy_q;
  assign packet_done_out     = done_q;
  assign overwrite_count_out = ovf_q;

endmodule

// File: tb/tb_fence_link_tx.sv
// Bench for fence_link_tx: packet-level reference model compared every cycle, plus
// directed scenarios with literal expectations (latency, bytes, sticky score, back-to-back, reset).
module tb_fence_link_tx;

  localparam int CPB = 4;
  localparam int PKT = 140 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [88:0] data = '0;
  logic        scored = 1'b0;
  logic        dv = 1'b0;
  logic        tx;
  logic        busy;
  logic        done;
  logic [7:0]  ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fence_link_tx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk_pixel_in       (clk),
    .rst_n_in           (rst_n),
    .data_in            (data),
    .scored_in          (scored),
    .data_valid_in      (dv),
    .tx_out             (tx),
    .busy_out           (busy),
    .packet_done_out    (done),
    .overwrite_count_out(ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Bit-serial CRC-8, poly 0x07, MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    logic [7:0] t;
    logic       fb;
    c = crc;
    t = b;
    for (int i = 0; i < 8; i++) begin
      fb = c[7] ^ t[7];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
      t = {t[6:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [7:0] ref_check(input logic [95:0] p);
    logic [95:0] t;
    logic [7:0]  c;
    t = p;
    c = 8'h00;
    for (int k = 0; k < 12; k++) begin
`ifdef FENCE_LINK_TX_CRC8_EN
      c = crc8_byte(c, t[7:0]);
`else
      c = c ^ t[7:0];
`endif
      t = t >> 8;
    end
    return c;
  endfunction

  // Line image of a whole packet: bit n is the level during bit period n.
  function automatic logic [139:0] frame_of(input logic [95:0] p);
    logic [139:0] f;
    logic [95:0]  t;
    logic [7:0]   b;
    f = '0;
    t = p;
    for (int k = 0; k < 14; k++) begin
      if (k == 0) begin
        b = 8'hA5;
      end else if (k == 13) begin
        b = ref_check(p);
      end else begin
        b = t[7:0];
        t = t >> 8;
      end
      f = {1'b1, b, 1'b0, f[139:10]};
    end
    return f;
  endfunction

  // Reference model state
  bit           m_active = 1'b0;
  int           m_pos = 0;
  logic [139:0] m_frame = '1;
  bit           m_pv = 1'b0;
  bit           m_ps = 1'b0;
  logic [88:0]  m_pd = '0;
  int           m_ovf = 0;
  bit           m_done = 1'b0;
  logic [89:0]  m_last_word = '0;
  int           launches = 0;

  initial begin : model
    logic         s_rst, s_dv, s_sc;
    logic [88:0]  s_d;
    logic [89:0]  word;
    logic [139:0] sh;
    bit           window;
    logic         exp_tx;
    forever begin
      @(posedge clk);
      s_rst = rst_n;
      s_dv  = dv;
      s_sc  = scored;
      s_d   = data;
      if (!s_rst) begin
        m_active = 1'b0;
        m_pos    = 0;
        m_pv     = 1'b0;
        m_ps     = 1'b0;
        m_pd     = '0;
        m_ovf    = 0;
        m_done   = 1'b0;
      end else begin
        m_done = 1'b0;
        window = !m_active || (m_pos == PKT - 1);
        if (m_active) begin
          if (m_pos == PKT - 1) begin
            m_done   = 1'b1;
            m_active = 1'b0;
          end else begin
            m_pos++;
          end
        end
        if (window && (s_dv || m_pv)) begin
          word        = s_dv ? {s_sc | m_ps, s_d} : {m_ps, m_pd};
          m_frame     = frame_of({6'b0, word});
          m_last_word = word;
          m_active    = 1'b1;
          m_pos       = 0;
          m_pv        = 1'b0;
          m_ps        = 1'b0;
          launches++;
          $display("pkt %0d launch scored=%0d data=%h t=%0t", launches, word[89], word[88:0], $time);
        end else if (s_dv) begin
          if (m_pv && m_ovf < 255) m_ovf++;
          m_pd = s_d;
          m_ps = m_ps | s_sc;
          m_pv = 1'b1;
        end
      end
      sh     = m_frame >> (m_pos / CPB);
      exp_tx = m_active ? sh[0] : 1'b1;
      #1;
      chk("tx_out", 32'(tx), 32'(exp_tx));
      chk("busy_out", 32'(busy), 32'(m_active));
      chk("packet_done_out", 32'(done), 32'(m_done));
      chk("overwrite_count_out", 32'(ovf), 32'(m_ovf));
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input logic [88:0] d, input logic s);
    @(negedge clk);
    data   = d;
    scored = s;
    dv     = 1'b1;
    @(negedge clk);
    dv     = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    chk("idle_within_budget", 32'(n < budget), 32'd1);
  endtask

  function automatic logic [88:0] rand_data();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[88:0];
  endfunction

  localparam logic [88:0] P_TEST = 89'h1_5555_AAAA_0000_1234_5678;

  initial begin : stim
    logic [PKT-1:0] hist;
    logic [PKT-1:0] sh;
    logic [7:0]     exp_b [14];
    logic [7:0]     got;
    logic [7:0]     c;
    string          s;
    int             cyc;
    int             npulse;

    // Model pins
    s = "123456789";
    c = 8'h00;
    for (int i = 0; i < 9; i++) c = crc8_byte(c, s[i]);
    chk("pin_crc8_check_value", 32'(c), 32'hF4);
`ifndef FENCE_LINK_TX_CRC8_EN
    chk("pin_xor_test_word", 32'(ref_check({6'b0, 1'b1, P_TEST})), 32'h0B);
`endif

    // Reset held 3 edges, then idle
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_tx", 32'(tx), 32'd1);
    chk("idle_ovf", 32'(ovf), 32'd0);

    // Single packet with literal byte decode
    exp_b = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'hAA, 8'hAA,
              8'h55, 8'h55, 8'h01, 8'h02, 8'h0B};
`ifdef FENCE_LINK_TX_CRC8_EN
    exp_b[13] = ref_check({6'b0, 1'b1, P_TEST});
`endif
    @(negedge clk);
    data = P_TEST; scored = 1'b1; dv = 1'b1;
    @(posedge clk); #1;
    dv = 1'b0;
    hist = {tx, hist[PKT-1:1]};
    chk("launch_tx_low", 32'(tx), 32'd0);
    chk("launch_busy", 32'(busy), 32'd1);
    cyc = 0;
    while (cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc < PKT) hist = {tx, hist[PKT-1:1]};
      if (done === 1'b1) break;
    end
    chk("done_latency", 32'(cyc), 32'(PKT));
    chk("busy_dropped", 32'(busy), 32'd0);
    for (int k = 0; k < 14; k++) begin
      for (int i = 0; i < 8; i++) begin
        sh = hist >> ((10 * k + 1 + i) * CPB + CPB / 2);
        got = {sh[0], got[7:1]};
      end
      chk($sformatf("byte%0d", k), 32'(got), 32'(exp_b[k]));
    end

    // Sticky score through an overwrite
    pulse(rand_data(), 1'b0);
    repeat (100) @(negedge clk);
    pulse(rand_data(), 1'b1);
    repeat (50) @(negedge clk);
    pulse(89'h2, 1'b0);
    chk("sticky_ovf", 32'(ovf), 32'd1);
    wait_idle(3 * PKT);
    chk("pin_sticky_scored", 32'(m_last_word[89]), 32'd1);
    chk("pin_sticky_data", 32'(m_last_word[88:0] == 89'h2), 32'd1);
    chk("sticky_ovf_after", 32'(ovf), 32'd1);

    // Back-to-back: strobe sampled on the final STOP cycle
    @(negedge clk);
    data = rand_data(); scored = 1'b0; dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    repeat (PKT - 1) @(negedge clk);
    data = rand_data(); dv = 1'b1;
    @(posedge clk); #1;
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_start_bit", 32'(tx), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    @(negedge clk);
    dv = 1'b0;
    npulse = 0;
    for (int n = 0; n < PKT + 10; n++) begin
      @(negedge clk);
      if (done === 1'b1) npulse++;
    end
    chk("b2b_done_pulses", 32'(npulse), 32'd1);
    chk("b2b_ovf_unchanged", 32'(ovf), 32'd1);

    // Reset during byte 5
    pulse(rand_data(), 1'b1);
    repeat (50 * CPB + 5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    pulse(rand_data(), 1'b0);
    wait_idle(2 * PKT);

    // Randomised traffic
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(1, PKT + 100)) @(negedge clk);
      pulse(rand_data(), 1'($urandom_range(0, 1)));
    end
    wait_idle(3 * PKT);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
